// File: rtl/dec_2_4_pulse_if.sv
// ---------------------------------------------------------------------------
// dec_2_4_pulse_if
//
// Purpose: valid/ready code channel feeding the sequential 2-to-4 decoder.
//
// Signals:
//   in_valid  upstream presents q/v this cycle
//   in_ready  decoder can accept a code this cycle
//   q         encoded line index, 0..3
//   v         code valid flag; 0 = null code
//
// Modports:
//   master  upstream side (drives in_valid/q/v, observes in_ready)
//   slave   decoder side (observes in_valid/q/v, drives in_ready)
// ---------------------------------------------------------------------------
interface dec_2_4_pulse_if;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] q;
    logic       v;

    modport master (
        output in_valid,
        output q,
        output v,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  q,
        input  v,
        output in_ready
    );
endinterface

// File: rtl/dec_2_4_pulse.sv
// ---------------------------------------------------------------------------
// dec_2_4_pulse
//
// Purpose: sequential 2-to-4 decoder. Accepts an encoded index (q, v) over a
// valid/ready handshake and drives the matching one-hot line on d_out_o for
// HOLD_CYCLES cycles, followed by GAP_CYCLES idle cycles before the next code
// can be taken. A null code (v=0) is consumed without any effect.
//
// Parameters:
//   HOLD_CYCLES  cycles each one-hot output stays asserted (1..255)
//   GAP_CYCLES   idle cycles after a pulse before in_ready returns (0..255)
//   CW           width of the optional per-line event counters
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      synchronous reset, active-low
//   bus        code channel (slave side): in_valid, in_ready, q, v
//   d_out_o    one-hot decoded strobe, registered
//   busy_o     high while driving a pulse or waiting out the gap
//   done_o     one-cycle pulse in the first cycle after a drive completes
//   cnt_sel_i  selects the line counter shown on cnt_val_o
//   cnt_val_o  event count for line cnt_sel_i (0 when counters are disabled)
//
// Build option:
//   DEC_2_4_CNT_EN  when defined, four CW-bit saturating counters record the
//                   number of accepted v=1 codes per line; otherwise no
//                   counters exist and cnt_val_o is tied to zero.
// ---------------------------------------------------------------------------
module dec_2_4_pulse #(
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 1,
    parameter int CW          = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    dec_2_4_pulse_if.slave       bus,
    output logic [3:0]           d_out_o,
    output logic                 busy_o,
    output logic                 done_o,
    input  logic [1:0]           cnt_sel_i,
    output logic [CW-1:0]        cnt_val_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } state_t;

    // Counter reload values; the timer counts down to zero so that the
    // state is left on the edge that ends the last cycle of the phase.
    localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0] GAP_LOAD  = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

    state_t     state_q, state_d;
    logic [7:0] tmr_q, tmr_d;
    logic [3:0] d_out_q, d_out_d;
    logic       done_q, done_d;

    logic       accept;
    logic       accept_code;
    logic [3:0] onehot;

    // Inputs are only looked at when a transfer actually happens.
    assign accept      = bus.in_valid && (state_q == IDLE);
    assign accept_code = accept && bus.v;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_onehot
            assign onehot[gi] = (bus.q == 2'(gi));
        end
    endgenerate

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            tmr_q   <= 8'd0;
            d_out_q <= 4'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            d_out_q <= d_out_d;
            done_q  <= done_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        d_out_d = d_out_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                // A null code is consumed here with no visible effect.
                if (accept_code) begin
                    state_d = DRIVE;
                    tmr_d   = HOLD_LOAD;
                    d_out_d = onehot;
                end
            end

            DRIVE: begin
                if (tmr_q == 8'd0) begin
                    d_out_d = 4'd0;
                    done_d  = 1'b1;
                    if (GAP_CYCLES > 0) begin
                        state_d = GAP;
                        tmr_d   = GAP_LOAD;
                    end else begin
                        // Returning straight to IDLE still leaves one zero
                        // cycle on d_out, since a new code needs an edge to
                        // be accepted before it can be driven.
                        state_d = IDLE;
                    end
                end else begin
                    tmr_d = tmr_q - 8'd1;
                end
            end

            GAP: begin
                if (tmr_q == 8'd0) begin
                    state_d = IDLE;
                end else begin
                    tmr_d = tmr_q - 8'd1;
                end
            end

            default: begin
                state_d = IDLE;
                tmr_d   = 8'd0;
                d_out_d = 4'd0;
            end
        endcase
    end

    assign bus.in_ready = (state_q == IDLE);
    assign busy_o       = (state_q != IDLE);
    assign d_out_o      = d_out_q;
    assign done_o       = done_q;

    // -----------------------------------------------------------------------
    // Optional per-line event counters
    // -----------------------------------------------------------------------
`ifdef DEC_2_4_CNT_EN
    logic [CW-1:0] ev_q [4];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_ev
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    ev_q[gi] <= '0;
                end else if (accept_code && onehot[gi] && (ev_q[gi] != '1)) begin
                    ev_q[gi] <= ev_q[gi] + CW'(1);
                end
            end
        end
    endgenerate

    assign cnt_val_o = ev_q[cnt_sel_i];
`else
    logic unused_cnt_sel;

    assign unused_cnt_sel = ^cnt_sel_i;
    assign cnt_val_o      = '0;
`endif

endmodule

// File: tb/tb_dec_2_4_pulse.sv
module tb_dec_2_4_pulse;

    localparam int CW = 2;

    logic          clk;
    logic          rst_n;

    // DUT with a one-cycle gap
    dec_2_4_pulse_if bus1 ();
    logic [3:0]    d1;
    logic          busy1, done1;
    logic [1:0]    sel1;
    logic [CW-1:0] cv1;

    // DUT with no gap
    dec_2_4_pulse_if bus0 ();
    logic [3:0]    d0;
    logic          busy0, done0;
    logic [1:0]    sel0;
    logic [CW-1:0] cv0;

    int checks = 0;
    int errors = 0;

    dec_2_4_pulse #(.HOLD_CYCLES(4), .GAP_CYCLES(1), .CW(CW)) u_g1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus1),
        .d_out_o   (d1),
        .busy_o    (busy1),
        .done_o    (done1),
        .cnt_sel_i (sel1),
        .cnt_val_o (cv1)
    );

    dec_2_4_pulse #(.HOLD_CYCLES(4), .GAP_CYCLES(0), .CW(CW)) u_g0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus0),
        .d_out_o   (d0),
        .busy_o    (busy0),
        .done_o    (done0),
        .cnt_sel_i (sel0),
        .cnt_val_o (cv0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Status of one DUT packed as {d_out, busy, done, in_ready}
    function automatic logic [31:0] st1();
        return {25'd0, d1, busy1, done1, bus1.in_ready};
    endfunction

    function automatic logic [31:0] st0();
        return {25'd0, d0, busy0, done0, bus0.in_ready};
    endfunction

    function automatic logic [31:0] cnt_exp(input int n);
`ifdef DEC_2_4_CNT_EN
        return (n > 3) ? 32'd3 : 32'(n);
`else
        return (n > 0) ? 32'd0 : 32'd0;
`endif
    endfunction

    initial begin
        rst_n         = 1'b0;
        bus1.in_valid = 1'b0; bus1.q = 2'd0; bus1.v = 1'b0; sel1 = 2'd0;
        bus0.in_valid = 1'b0; bus0.q = 2'd0; bus0.v = 1'b0; sel0 = 2'd0;

        // ---- 1. reset then idle ----
        tick(); tick();
        check("rst_hold_g1", st1(), {25'd0, 4'b0000, 1'b0, 1'b0, 1'b1});
        rst_n = 1'b1;
        tick();
        check("rst_idle_g1", st1(), {25'd0, 4'b0000, 1'b0, 1'b0, 1'b1});
        check("rst_idle_g0", st0(), {25'd0, 4'b0000, 1'b0, 1'b0, 1'b1});
        check("rst_cnt_g1", 32'(cv1), 32'd0);

        // ---- 2. single code q=2, HOLD=4, GAP=1 ----
        bus1.in_valid = 1'b1; bus1.q = 2'd2; bus1.v = 1'b1;
        tick();
        $display("txn g1 accept q=2 v=1");
        // keep offering a different code while busy; it must be ignored
        bus1.q = 2'd0;
        check("single_t1", st1(), {25'd0, 4'b0100, 1'b1, 1'b0, 1'b0});
        for (int i = 2; i <= 4; i++) begin
            tick();
            check($sformatf("single_t%0d", i), st1(), {25'd0, 4'b0100, 1'b1, 1'b0, 1'b0});
        end
        tick();
        check("single_done", st1(), {25'd0, 4'b0000, 1'b1, 1'b1, 1'b0});
        bus1.in_valid = 1'b0;
        tick();
        check("single_ready", st1(), {25'd0, 4'b0000, 1'b0, 1'b0, 1'b1});
        sel1 = 2'd2;
        #1;
        check("single_cnt_l2", 32'(cv1), cnt_exp(1));

        // ---- 3. null code q=3, v=0 ----
        bus1.in_valid = 1'b1; bus1.q = 2'd3; bus1.v = 1'b0;
        tick();
        $display("txn g1 accept q=3 v=0");
        bus1.in_valid = 1'b0;
        check("null_t1", st1(), {25'd0, 4'b0000, 1'b0, 1'b0, 1'b1});
        tick();
        check("null_t2", st1(), {25'd0, 4'b0000, 1'b0, 1'b0, 1'b1});
        sel1 = 2'd3;
        #1;
        check("null_cnt_l3", 32'(cv1), 32'd0);

        // ---- 4. back-to-back with GAP=0 ----
        bus0.in_valid = 1'b1; bus0.q = 2'd1; bus0.v = 1'b1;
        tick();
        $display("txn g0 accept q=1 v=1");
        bus0.q = 2'd3;
        check("b2b_a_t1", st0(), {25'd0, 4'b0010, 1'b1, 1'b0, 1'b0});
        for (int i = 2; i <= 4; i++) begin
            tick();
            check($sformatf("b2b_a_t%0d", i), st0(), {25'd0, 4'b0010, 1'b1, 1'b0, 1'b0});
        end
        tick();
        check("b2b_gap", st0(), {25'd0, 4'b0000, 1'b0, 1'b1, 1'b1});
        tick();
        $display("txn g0 accept q=3 v=1");
        bus0.in_valid = 1'b0;
        check("b2b_b_t1", st0(), {25'd0, 4'b1000, 1'b1, 1'b0, 1'b0});
        for (int i = 2; i <= 4; i++) begin
            tick();
            check($sformatf("b2b_b_t%0d", i), st0(), {25'd0, 4'b1000, 1'b1, 1'b0, 1'b0});
        end
        tick();
        check("b2b_b_done", st0(), {25'd0, 4'b0000, 1'b0, 1'b1, 1'b1});
        tick();
        check("b2b_idle", st0(), {25'd0, 4'b0000, 1'b0, 1'b0, 1'b1});
        sel0 = 2'd3;
        #1;
        check("b2b_cnt_l3", 32'(cv0), cnt_exp(1));

        // ---- 5. reset in the middle of a drive ----
        bus1.in_valid = 1'b1; bus1.q = 2'd0; bus1.v = 1'b1;
        tick();
        $display("txn g1 accept q=0 v=1");
        bus1.in_valid = 1'b0;
        check("mid_t1", st1(), {25'd0, 4'b0001, 1'b1, 1'b0, 1'b0});
        tick();
        check("mid_t2", st1(), {25'd0, 4'b0001, 1'b1, 1'b0, 1'b0});
        rst_n = 1'b0;
        tick();
        check("mid_rst", st1(), {25'd0, 4'b0000, 1'b0, 1'b0, 1'b1});
        rst_n = 1'b1;
        tick();
        check("mid_rel", st1(), {25'd0, 4'b0000, 1'b0, 1'b0, 1'b1});
        tick();
        check("mid_nodone", st1(), {25'd0, 4'b0000, 1'b0, 1'b0, 1'b1});
        sel1 = 2'd2;
        sel0 = 2'd3;
        #1;
        check("mid_cnt_clr_g1", 32'(cv1), 32'd0);
        check("mid_cnt_clr_g0", 32'(cv0), 32'd0);

        // ---- 6. saturating counter on line 1 ----
        sel0 = 2'd1;
        for (int n = 1; n <= 5; n++) begin
            bus0.in_valid = 1'b1; bus0.q = 2'd1; bus0.v = 1'b1;
            tick();
            $display("txn g0 accept q=1 v=1 (%0d)", n);
            bus0.in_valid = 1'b0;
            check($sformatf("sat_d_%0d", n), 32'(d0), 32'h2);
            repeat (4) tick();
            check($sformatf("sat_done_%0d", n), st0(), {25'd0, 4'b0000, 1'b0, 1'b1, 1'b1});
            check($sformatf("sat_cnt_%0d", n), 32'(cv0), cnt_exp(n));
        end
        sel0 = 2'd0;
        #1;
        check("sat_cnt_l0", 32'(cv0), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
